// File: rtl/if_id_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : if_id_fifo_if
// Description : Fetch-side push bus and decode-side head bus of the IF/ID
//               pipeline FIFO, bundled with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_id_fifo_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_pc;
    logic [ADDR_W-1:0] in_pc4;
    logic [INST_W-1:0] in_inst;
    logic              out_valid;
    logic [ADDR_W-1:0] out_pc;
    logic [ADDR_W-1:0] out_pc4;
    logic [INST_W-1:0] out_inst;

    // Master: the pipeline around the FIFO (fetch pushes, decode observes).
    modport master (
        output in_valid, in_pc, in_pc4, in_inst,
        input  in_ready, out_valid, out_pc, out_pc4, out_inst
    );

    // Slave: the FIFO itself.
    modport slave (
        input  in_valid, in_pc, in_pc4, in_inst,
        output in_ready, out_valid, out_pc, out_pc4, out_inst
    );
endinterface
`default_nettype wire

// File: rtl/if_id_fifo.sv
`default_nettype none
// ============================================================================
// Module      : if_id_fifo
// Description : IF/ID pipeline buffer. Holds up to DEPTH fetched entries
//               (PC, PC+4, instruction), supports decode stall, pipeline
//               flush and a saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_fifo #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 2,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013),
    parameter int                CNT_W    = 16
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    if_id_fifo_if.slave                   bus,
    input  wire logic                     flush,
    input  wire logic                     stall,
    output logic                          out_flushed,
    output logic [$clog2(DEPTH):0]        count,
    output logic [CNT_W-1:0]              stall_cnt
);

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                CW      = PTR_W + 1;
    localparam logic [CW-1:0]     c_depth = CW'(DEPTH);
    localparam logic [PTR_W-1:0]  c_last  = PTR_W'(DEPTH - 1);

    // Storage is deliberately not reset; it is masked whenever no entry is valid.
    logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
    logic [ADDR_W-1:0] r_pc4_mem  [DEPTH];
    logic [INST_W-1:0] r_inst_mem [DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_flushed;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_valid;
    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic [PTR_W-1:0]  w_wr_next;
    logic [PTR_W-1:0]  w_rd_next;

    // Handshake decode; ready comes only from the registered count so the
    // fetch stage never sees a combinational path from stall or flush.
    always_comb begin
        w_valid   = (r_count != '0);
        w_ready   = (r_count < c_depth);
        w_push    = bus.in_valid & w_ready & ~flush;
        w_pop     = w_valid & ~stall & ~flush;
        w_wr_next = (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
        w_rd_next = (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
    end

    // Entry storage: write the fetched triple at the write pointer on a push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= bus.in_pc;
            r_pc4_mem[r_wr_ptr]  <= bus.in_pc4;
            r_inst_mem[r_wr_ptr] <= bus.in_inst;
        end
    end

    // Pointers and occupancy; flush wins over every other update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_next;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // One-cycle flush acknowledge and saturating count of stalled-head cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flushed   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_flushed <= flush;
            if (w_valid && stall && !flush && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    // Head presentation: the stored entry while valid, a bubble otherwise.
    always_comb begin
        bus.in_ready  = w_ready;
        bus.out_valid = w_valid;
        bus.out_pc    = '0;
        bus.out_pc4   = '0;
        bus.out_inst  = NOP_INST;
        if (w_valid) begin
            bus.out_pc   = r_pc_mem[r_rd_ptr];
            bus.out_pc4  = r_pc4_mem[r_rd_ptr];
            bus.out_inst = r_inst_mem[r_rd_ptr];
        end
    end

    assign count       = r_count;
    assign out_flushed = r_flushed;
    assign stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_if_id_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_fifo
// Description : Self-checking bench for if_id_fifo: directed scenarios plus
//               randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_fifo;

    localparam int          DEPTH = 4;
    localparam int          CNT_W = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
    } entry_t;

    logic clk;
    logic rst;
    logic flush;
    logic stall;
    logic out_flushed;
    logic [$clog2(DEPTH):0] count;
    logic [CNT_W-1:0]       stall_cnt;

    if_id_fifo_if #(.ADDR_W(32), .INST_W(32)) bus ();

    if_id_fifo #(
        .ADDR_W   (32),
        .INST_W   (32),
        .DEPTH    (DEPTH),
        .NOP_INST (NOP),
        .CNT_W    (CNT_W)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .flush       (flush),
        .stall       (stall),
        .out_flushed (out_flushed),
        .count       (count),
        .stall_cnt   (stall_cnt)
    );

    // Reference model state
    entry_t m_q[$];
    int     m_stall_cnt;
    logic   m_flushed;

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit          v;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic [31:0] e_inst;
        v      = (m_q.size() > 0);
        e_pc   = v ? m_q[0].pc   : 32'h0;
        e_pc4  = v ? m_q[0].pc4  : 32'h0;
        e_inst = v ? m_q[0].inst : NOP;
        check("out_valid",   64'(bus.out_valid), 64'(v));
        check("out_pc",      64'(bus.out_pc),    64'(e_pc));
        check("out_pc4",     64'(bus.out_pc4),   64'(e_pc4));
        check("out_inst",    64'(bus.out_inst),  64'(e_inst));
        check("count",       64'(count),         64'(m_q.size()));
        check("in_ready",    64'(bus.in_ready),  64'(m_q.size() < DEPTH));
        check("out_flushed", 64'(out_flushed),   64'(m_flushed));
        check("stall_cnt",   64'(stall_cnt),     64'(m_stall_cnt));
    endtask

    // Behavioural rules for one clock edge given the inputs seen at that edge.
    task automatic model_step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                              input logic st, input logic fl);
        bit     do_push;
        bit     do_pop;
        entry_t e;
        if (fl) begin
            m_q.delete();
            m_flushed = 1'b1;
        end else begin
            m_flushed = 1'b0;
            do_push = v && (m_q.size() < DEPTH);
            do_pop  = (m_q.size() > 0) && !st;
            if ((m_q.size() > 0) && st && (m_stall_cnt < (2**CNT_W) - 1))
                m_stall_cnt++;
            if (do_pop)
                void'(m_q.pop_front());
            if (do_push) begin
                e.pc   = pc;
                e.pc4  = pc + 32'd4;
                e.inst = inst;
                m_q.push_back(e);
            end
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_stall_cnt = 0;
        m_flushed   = 1'b0;
    endtask

    // One cycle: check the state left by the previous edge, drive, clock, model.
    task automatic tick(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic st, input logic fl);
        @(negedge clk);
        check_outputs();
        bus.in_valid = v;
        bus.in_pc    = pc;
        bus.in_pc4   = pc + 32'd4;
        bus.in_inst  = inst;
        stall        = st;
        flush        = fl;
        @(posedge clk);
        model_step(v, pc, inst, st, fl);
    endtask

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        stall        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_pc    = '0;
        bus.in_pc4   = '0;
        bus.in_inst  = '0;
        model_reset();

        // Reset state, observed while reset is still held.
        #3;
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_inst",  64'(bus.out_inst),  64'(NOP));
        check("rst_ready", 64'(bus.in_ready),  64'd1);
        check("rst_count", 64'(count),         64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single push into an empty FIFO, latency one, then drains.
        tick(1'b1, 32'h100, 32'h0050_0093, 1'b0, 1'b0);
        #1;
        check("single_valid", 64'(bus.out_valid), 64'd1);
        check("single_pc",    64'(bus.out_pc),    64'h100);
        check("single_pc4",   64'(bus.out_pc4),   64'h104);
        check("single_inst",  64'(bus.out_inst),  64'h0050_0093);
        tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        check("single_drain_valid", 64'(bus.out_valid), 64'd0);
        check("single_drain_inst",  64'(bus.out_inst),  64'h13);

        // Stall with buffering: fill completely, an extra push is ignored.
        for (int i = 0; i < DEPTH; i++)
            tick(1'b1, 32'h200 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b1, 1'b0);
        tick(1'b1, 32'h2F0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        #1;
        check("full_count", 64'(count),        64'(DEPTH));
        check("full_ready", 64'(bus.in_ready), 64'd0);
        check("full_head",  64'(bus.out_pc),   64'h200);
        for (int i = 0; i < DEPTH; i++)
            tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Flush priority over stall and push with a partly filled FIFO.
        tick(1'b1, 32'h400, 32'h1111_0000, 1'b1, 1'b0);
        tick(1'b1, 32'h404, 32'h1111_0004, 1'b1, 1'b0);
        tick(1'b1, 32'h408, 32'h1111_0008, 1'b1, 1'b1);
        #1;
        check("flush_count", 64'(count),         64'd0);
        check("flush_valid", 64'(bus.out_valid), 64'd0);
        check("flush_pulse", 64'(out_flushed),   64'd1);
        tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        check("flush_pulse_end", 64'(out_flushed), 64'd0);

        // Wrap-around: ten back-to-back pushes with alternating stall.
        for (int i = 0; i < 10; i++)
            tick(1'b1, 32'(4 * i), 32'h5500_0000 + 32'(i), (i % 2) == 0, 1'b0);
        for (int i = 0; i < 8; i++)
            tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Saturation of the stall counter.
        tick(1'b1, 32'h500, 32'h7777_0000, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++)
            tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #1;
        check("stall_sat", 64'(stall_cnt), 64'd15);
        tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Asynchronous reset between edges with three entries held.
        for (int i = 0; i < 3; i++)
            tick(1'b1, 32'h600 + 32'(4 * i), 32'h6600_0000 + 32'(i), 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid",   64'(bus.out_valid), 64'd0);
        check("arst_count",   64'(count),         64'd0);
        check("arst_pc",      64'(bus.out_pc),    64'd0);
        check("arst_inst",    64'(bus.out_inst),  64'(NOP));
        check("arst_ready",   64'(bus.in_ready),  64'd1);
        check("arst_stalls",  64'(stall_cnt),     64'd0);
        model_reset();
        bus.in_valid = 1'b0;
        stall        = 1'b0;
        flush        = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick(1'b1, 32'h300, 32'h3300_0000, 1'b0, 1'b0);
        #1;
        check("post_rst_head", 64'(bus.out_pc), 64'h300);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 3) != 0,
                 {$urandom_range(0, 32'h3FFF), 2'b00},
                 $urandom,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 24) == 0);
        end
        @(negedge clk);
        check_outputs();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_id_fifo.md
IF_ID_FIFO -- requirements
Module: if_id_fifo

Interface
REQ-001 Parameter ADDR_W, default 32, width of the PC and PC+4 fields.
REQ-002 Parameter INST_W, default 32, width of the instruction field.
REQ-003 Parameter DEPTH, default 2, number of entries; legal values are 2, 4 and 8.
REQ-004 Parameter NOP_INST, default 32'h0000_0013, instruction presented when no entry is valid.
REQ-005 Parameter CNT_W, default 16, width of the stall counter.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 in_valid  in  1  fetch stage presents a valid entry.
REQ-009 in_ready  out  1  FIFO can accept an entry this cycle.
REQ-010 in_pc  in  ADDR_W  PC of the fetched instruction.
REQ-011 in_pc4  in  ADDR_W  PC+4 of the fetched instruction.
REQ-012 in_inst  in  INST_W  instruction word from instruction memory.
REQ-013 flush  in  1  discard all held and incoming entries.
REQ-014 stall  in  1  decode stage cannot consume the head entry.
REQ-015 out_valid  out  1  head entry is valid.
REQ-016 out_pc  out  ADDR_W  PC of the head entry.
REQ-017 out_pc4  out  ADDR_W  PC+4 of the head entry.
REQ-018 out_inst  out  INST_W  instruction of the head entry.
REQ-019 out_flushed  out  1  registered one-cycle pulse following an accepted flush.
REQ-020 count  out  $clog2(DEPTH)+1  number of valid entries.
REQ-021 stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and stall=1.

Function
REQ-022 A push SHALL occur when in_valid=1, in_ready=1 and flush=0; the entry is written at the write pointer.
REQ-023 A pop SHALL occur when out_valid=1, stall=0 and flush=0; the read pointer advances.
REQ-024 in_ready SHALL be 1 exactly when count<DEPTH, and SHALL NOT depend combinationally on stall or flush.
REQ-025 A pushed entry SHALL appear at the outputs one cycle after the push edge when the FIFO was empty (latency 1).
REQ-026 out_pc, out_pc4 and out_inst SHALL reflect the head entry while out_valid=1.
REQ-027 While out_valid=0, out_pc and out_pc4 SHALL be 0 and out_inst SHALL be NOP_INST.
REQ-028 A push and a pop in the same cycle SHALL leave count unchanged and advance both pointers.
REQ-029 Both pointers SHALL wrap from DEPTH-1 to 0.
REQ-030 A held entry's contents SHALL NOT change while stall=1 (the instruction word is buffered with its PC).
REQ-031 When flush=1, the next edge SHALL set count and both pointers to 0, suppress any push or pop, and set out_flushed=1.
REQ-032 flush SHALL take priority over stall, push and pop.
REQ-033 out_flushed SHALL be 0 on every edge where flush=0.
REQ-034 stall_cnt SHALL increment by 1 on each edge where out_valid=1, stall=1 and flush=0, and SHALL saturate at 2^CNT_W-1.
REQ-035 A push attempted while full SHALL have no effect: in_ready=0 and the contents are unchanged.
REQ-036 out_valid SHALL be 1 exactly when count>0.

Reset
REQ-037 On rst=1, the block SHALL set count=0, both pointers=0, out_valid=0, out_pc=0, out_pc4=0, out_inst=NOP_INST, out_flushed=0, stall_cnt=0 and in_ready=1, without waiting for a clock edge.
REQ-038 Storage contents are not required to reset, but SHALL NOT be visible while out_valid=0.
REQ-039 Reset asserted mid-operation SHALL discard all entries immediately; the first push after release SHALL behave as a push into an empty FIFO.

Verification
REQ-040 Single push: push pc=0x100, inst=0x00500093 into an empty FIFO with stall=0 -> the next cycle shows out_valid=1, out_pc=0x100, out_pc4=0x104, out_inst=0x00500093; the cycle after shows out_valid=0 and out_inst=0x13.
REQ-041 Stall with buffering (DEPTH=2): hold stall=1 and push 0x200 then 0x204 -> count=2, in_ready=0, a third push is ignored and the head stays 0x200; release stall -> 0x200 then 0x204 pop in order and stall_cnt=2.
REQ-042 Flush priority: with count=2 and stall=1, assert flush together with in_valid=1 -> the next cycle shows count=0, out_valid=0, out_flushed=1 and no entry written; the cycle after shows out_flushed=0.
REQ-043 Wrap-around (DEPTH=4): run 10 back-to-back pushes of pc=0x0..0x24 with alternating stall -> the output order matches the input order, count never exceeds 4, and no entries are lost or duplicated.
REQ-044 Saturation (CNT_W=4): hold out_valid=1 and stall=1 for 20 cycles -> stall_cnt reaches 15 and holds.
REQ-045 Async reset: assert rst between edges while count=3 -> outputs go to their reset values immediately; after release, push 0x300 -> it appears one cycle later as the head.
